// File: rtl/ffm_arbiter.sv
// ffm_arbiter: round-robin arbiter sharing one field multiplier among NREQ
// requesters. A winner's operands are latched and issued with a one-cycle
// mul_start; the result (or a timeout error) is returned as a one-cycle pulse
// on the owner's rsp_valid bit.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             per-requester request level, held until its rsp_valid bit
//   req_a, req_b    operands, requester i in bits [i*W +: W]
//   grant           one-hot owner of the multiplier, 0 when idle
//   rsp_valid       one-cycle pulse on the owner's bit when the result is ready
//   rsp_data        product for the pulsed requester (0 on timeout)
//   rsp_err         qualifies rsp_valid: 1 = timeout
//   busy            high whenever the arbiter is not idle
//   mul_start       one-cycle start pulse to the multiplier
//   mul_a, mul_b    multiplier operands, stable for the whole operation
//   mul_res         multiplier result
//   mul_valid       multiplier result valid
module ffm_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 255,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [W-1:0]      mul_res,
  input  logic              mul_valid
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_rsp_valid;
  logic [W-1:0]    r_rsp_data;
  logic            r_rsp_err;
  logic            r_busy;
  logic            r_mul_start;
  logic [W-1:0]    r_mul_a;
  logic [W-1:0]    r_mul_b;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [NREQ-1:0] w_win_oh;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;

  assign grant     = r_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;

  // Round-robin pick: first requester above ptr, then wrap to 0..ptr.
  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    w_a      = '0;
    w_b      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && req[i] && (PW'(i) > r_ptr)) begin
        w_found     = 1'b1;
        w_win       = PW'(i);
        w_win_oh[i] = 1'b1;
        w_a         = req_a[i*W +: W];
        w_b         = req_b[i*W +: W];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && req[i] && (PW'(i) <= r_ptr)) begin
        w_found     = 1'b1;
        w_win       = PW'(i);
        w_win_oh[i] = 1'b1;
        w_a         = req_a[i*W +: W];
        w_b         = req_b[i*W +: W];
      end
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= PW'(NREQ - 1);
      r_cnt       <= '0;
      r_grant     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_win_oh;
            r_mul_a     <= w_a;
            r_mul_b     <= w_b;
            r_mul_start <= 1'b1;
            r_ptr       <= w_win;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_mul_start <= 1'b0;
          r_cnt       <= r_cnt + CW'(1);
          // mul_valid during the start cycle is stale and must not complete the op.
          if (!r_mul_start && mul_valid) begin
            r_rsp_data  <= mul_res;
            r_rsp_valid <= r_grant;
            r_rsp_err   <= 1'b0;
            r_state     <= S_RESP;
          end else if ((r_cnt + CW'(1)) == CW'(TIMEOUT)) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= r_grant;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid <= '0;
          r_rsp_err   <= 1'b0;
          r_grant     <= '0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ffm_arbiter.md
FFM_ARBITER -- requirements
Module: ffm_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one field multiplier.
REQ-002 SHALL have parameter W, default 255, operand/result width.
REQ-003 SHALL have parameter TIMEOUT, default 1023, max cycles waited for mul_valid.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NREQ  per-requester request level; held with operands until matching rsp_valid bit.
REQ-007 req_a  input  NREQ*W  operand A per requester, slice i = bits [i*W +: W].
REQ-008 req_b  input  NREQ*W  operand B per requester, same slicing.
REQ-009 grant  output  NREQ  one-hot owner of multiplier, 0 when idle.
REQ-010 rsp_valid  output  NREQ  one-cycle pulse on owner's bit when result ready.
REQ-011 rsp_data  output  W  product for the pulsed requester.
REQ-012 rsp_err  output  1  qualifies rsp_valid; 1 = timeout, rsp_data = 0.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 mul_start  output  1  one-cycle start pulse to multiplier.
REQ-015 mul_a, mul_b  output  W  multiplier operands, stable from start until result accepted.
REQ-016 mul_res  input  W  multiplier result.
REQ-017 mul_valid  input  1  multiplier result valid.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-019 IDLE: if req != 0, SHALL pick winner round-robin (search from ptr+1 upward, wrapping), set grant one-hot, latch winner's req_a/req_b into mul_a/mul_b, set mul_start=1, ptr=winner, clear timeout counter, go WAIT; else stay.
REQ-020 WAIT: SHALL clear mul_start after one cycle; SHALL ignore mul_valid in the first WAIT cycle (cycle mul_start is high).
REQ-021 WAIT, mul_valid=1 (after first cycle): rsp_data=mul_res, rsp_valid=grant, rsp_err=0, go RESP.
REQ-022 WAIT, counter reaches TIMEOUT without valid: rsp_data=0, rsp_valid=grant, rsp_err=1, go RESP; counter 16 bits, increments once per WAIT cycle.
REQ-023 RESP: rsp_valid=0, rsp_err=0, grant=0, go IDLE; rsp_data holds last value.
REQ-024 Issue latency: req sampled at edge t -> mul_start high cycle t+1; result pulse one cycle after mul_valid sampled.
REQ-025 Non-winning requests SHALL wait; none dropped; req changes during WAIT/RESP SHALL not alter grant or mul_a/mul_b.
REQ-026 Requester re-asserting immediately after its response SHALL lose to any other pending requester (ptr fairness).
REQ-027 mul_valid in IDLE or RESP SHALL be ignored.
REQ-028 Single requester continuously requesting SHALL be served back-to-back, one op per (multiplier latency + 3) cycles.

Reset
REQ-029 rst SHALL immediately force IDLE, grant=0, rsp_valid=0, rsp_err=0, rsp_data=0, mul_start=0, mul_a=mul_b=0, busy=0, counter=0, ptr=NREQ-1 (requester 0 first).
REQ-030 rst mid-WAIT SHALL abandon the op with no response pulse; first op after release restarts arbitration from requester 0.

Verification
REQ-031 Single op: req=0001, a=3, b=5, 5-cycle multiplier model -> one mul_start, rsp_valid=0001, rsp_data=15, rsp_err=0, busy low after RESP.
REQ-032 Contention: req=1111 held, each dropped after its response -> grant order 0,1,2,3; each rsp_valid one cycle, no overlap.
REQ-033 Fairness: req0 and req2 persistently re-asserted -> grants alternate 0,2,0,2.
REQ-034 Timeout: TIMEOUT=8, multiplier never valid -> rsp_valid on owner with rsp_err=1, rsp_data=0, 8 WAIT cycles after start.
REQ-035 Stale valid: mul_valid high in IDLE and first WAIT cycle -> ignored; response only on later valid.
REQ-036 Reset mid-op: rst in WAIT -> all outputs zero, no rsp_valid; after release req=0100 -> grant=0100, correct product returned.
